// File: rtl/kmeans_pkg.sv
`default_nettype none
// kmeans_pkg: shared constants, types and reset helper for the k-means centroid update path.
// Rev 1.0. Macro CENTROID_ROUND_EN widens the divider dividend by one bit for round-to-nearest.
`ifndef K
`define K 14
`endif

package kmeans_pkg;

  localparam int K_CLUSTERS = `K;
  localparam int DIMS       = 5;
  localparam int DW         = 7;
  localparam int LW         = 4;
  localparam int MAX_PTS    = 300;
  localparam int CNT_W      = 9;
  localparam int SUM_W      = 16;
`ifdef CENTROID_ROUND_EN
  localparam int DVD_W      = SUM_W + 1;
`else
  localparam int DVD_W      = SUM_W;
`endif
  localparam int DIV_LEN    = K_CLUSTERS * DIMS * (DVD_W + 1);

  typedef logic [DIMS-1:0][DW-1:0] point_t;

  typedef struct packed {
    logic [LW-1:0] label;
    point_t        point;
  } element_t;

  typedef point_t [K_CLUSTERS-1:0] centroid_arr_t;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIV     = 2'd1,
    PUBLISH = 2'd2
  } cu_state_t;

  // Power-on centroid set: cluster k sits at k*8 in every dimension.
  function automatic centroid_arr_t reset_centroids();
    centroid_arr_t c;
    for (int k = 0; k < K_CLUSTERS; k++) begin
      for (int d = 0; d < DIMS; d++) begin
        c[k][d] = DW'(k * 8);
      end
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/centroid_update_unit_seq_divider.sv
`default_nettype none
// seq_divider: restoring unsigned divider, one quotient bit per cycle, MSB first.
// Rev 1.0. done/quotient are combinational in the final iteration cycle so the caller can capture on that edge.

module seq_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int IW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] quo;
  logic [IW-1:0]    iter;
  logic             running;

  logic [DVS_W:0]   trial;
  logic             fits;
  logic [DVS_W-1:0] rem_next;
  logic [DVD_W-1:0] quo_next;

  // The remainder is always below the divisor, so the shifted trial fits in DVS_W+1 bits.
  always_comb begin
    trial    = {rem, quo[DVD_W-1]};
    fits     = trial >= {1'b0, divisor};
    rem_next = fits ? DVS_W'(trial - {1'b0, divisor}) : DVS_W'(trial);
    quo_next = {quo[DVD_W-2:0], fits};
  end

  assign done     = running && (iter == IW'(1));
  assign quotient = quo_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      quo     <= dividend;
      iter    <= IW'(DVD_W);
      running <= 1'b1;
    end else if (running) begin
      rem  <= rem_next;
      quo  <= quo_next;
      iter <= iter - IW'(1);
      if (iter == IW'(1)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/centroid_update_unit.sv
`default_nettype none
// centroid_update_unit: per-cluster sums/counts, sequential mean division, centroid publish.
// Rev 1.0. Optional macro CENTROID_ROUND_EN selects round-to-nearest instead of truncating means.

module centroid_update_unit
  import kmeans_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  element_t      element_in,
  input  logic          recalculate_centroids,
  output logic          ready,
  output logic          busy,
  output centroid_arr_t formatted_centroids,
  output logic          update_centroids
);

  localparam int                PH_W     = $clog2(DVD_W + 1);
  localparam int                DM_W     = $clog2(DIMS);
  localparam logic [LW-1:0]     NUM_LBL  = LW'(K_CLUSTERS);
  localparam logic [LW-1:0]     LAST_CL  = LW'(K_CLUSTERS - 1);
  localparam logic [DM_W-1:0]   LAST_DM  = DM_W'(DIMS - 1);
  localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(DVD_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_PTS);
  localparam logic [DVD_W-1:0]  Q_MAX    = DVD_W'((1 << DW) - 1);

  cu_state_t        state;
  logic [SUM_W-1:0] sums   [K_CLUSTERS][DIMS];
  logic [CNT_W-1:0] counts [K_CLUSTERS];
  centroid_arr_t    shadow;
  logic [LW-1:0]    cl;
  logic [DM_W-1:0]  dm;
  logic [PH_W-1:0]  phase;

  logic [SUM_W-1:0] cur_sum;
  logic [CNT_W-1:0] cur_cnt;
  logic [DVD_W-1:0] dividend;
  logic             div_start;
  logic             div_done;
  logic [DVD_W-1:0] quotient;
  logic [DW-1:0]    result;
  centroid_arr_t    shadow_next;
  logic             accept;

  always_comb begin
    cur_sum = sums[cl][dm];
    cur_cnt = counts[cl];
`ifdef CENTROID_ROUND_EN
    dividend = DVD_W'(cur_sum) + DVD_W'(cur_cnt >> 1);
`else
    dividend = cur_sum;
`endif
    div_start = (state == DIV) && (phase == '0);

    // Empty clusters keep their centroid; the divider still runs so DIV length stays fixed.
    if (cur_cnt == '0) begin
      result = formatted_centroids[cl][dm];
    end else if (quotient > Q_MAX) begin
      result = DW'(Q_MAX);
    end else begin
      result = quotient[DW-1:0];
    end

    shadow_next = shadow;
    if ((state == DIV) && div_done) begin
      shadow_next[cl][dm] = result;
    end

    accept = valid && ready && (element_in.label < NUM_LBL)
             && (counts[element_in.label] < CNT_MAX);
  end

  seq_divider #(
    .DVD_W (DVD_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cur_cnt),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ACCUM;
      ready               <= 1'b1;
      busy                <= 1'b0;
      update_centroids    <= 1'b0;
      cl                  <= '0;
      dm                  <= '0;
      phase               <= '0;
      formatted_centroids <= reset_centroids();
      shadow              <= reset_centroids();
      for (int k = 0; k < K_CLUSTERS; k++) begin
        counts[k] <= '0;
        for (int d = 0; d < DIMS; d++) begin
          sums[k][d] <= '0;
        end
      end
    end else begin
      update_centroids <= 1'b0;
      case (state)
        ACCUM: begin
          if (accept) begin
            for (int d = 0; d < DIMS; d++) begin
              sums[element_in.label][d] <= sums[element_in.label][d] + SUM_W'(element_in.point[d]);
            end
            counts[element_in.label] <= counts[element_in.label] + CNT_W'(1);
          end
          if (recalculate_centroids) begin
            state <= DIV;
            ready <= 1'b0;
            busy  <= 1'b1;
            cl    <= '0;
            dm    <= '0;
            phase <= '0;
          end
        end
        DIV: begin
          shadow <= shadow_next;
          if (phase == LAST_PH) begin
            phase <= '0;
            if (dm == LAST_DM) begin
              dm <= '0;
              if (cl == LAST_CL) begin
                cl                  <= '0;
                state               <= PUBLISH;
                busy                <= 1'b0;
                update_centroids    <= 1'b1;
                formatted_centroids <= shadow_next;
              end else begin
                cl <= cl + LW'(1);
              end
            end else begin
              dm <= dm + DM_W'(1);
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        PUBLISH: begin
          for (int k = 0; k < K_CLUSTERS; k++) begin
            counts[k] <= '0;
            for (int d = 0; d < DIMS; d++) begin
              sums[k][d] <= '0;
            end
          end
          state <= ACCUM;
          ready <= 1'b1;
        end
        default: begin
          state <= ACCUM;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_centroid_update_unit.sv
`default_nettype none
// tb_centroid_update_unit: table-driven and randomized checks of centroid_update_unit against a mean model.

module tb_centroid_update_unit;
  import kmeans_pkg::*;

`ifdef CENTROID_ROUND_EN
  localparam bit ROUND    = 1'b1;
  localparam int PAIR_CYC = 18;
`else
  localparam bit ROUND    = 1'b0;
  localparam int PAIR_CYC = 17;
`endif
  localparam int NK      = 14;
  localparam int ND      = 5;
  localparam int DIV_CYC = NK * ND * PAIR_CYC;
  // Counting the request cycle as cycle 1, the pulse is in cycle DIV_CYC+2, i.e. DIV_CYC+1 edges later.
  localparam int EXP_LAT = DIV_CYC + 1;

  logic          clk;
  logic          reset;
  logic          valid;
  logic [38:0]   element_in;
  logic          recalc;
  logic          ready;
  logic          busy;
  centroid_arr_t fc;
  logic          update;

  centroid_update_unit dut (
    .clk                   (clk),
    .reset                 (reset),
    .valid                 (valid),
    .element_in            (element_in),
    .recalculate_centroids (recalc),
    .ready                 (ready),
    .busy                  (busy),
    .formatted_centroids   (fc),
    .update_centroids      (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pulse_cnt = 0;
  always @(negedge clk) if (update === 1'b1) pulse_cnt++;

  int n_pass  = 0;
  int n_total = 0;

  int m_sum  [NK][ND];
  int m_cnt  [NK];
  int m_cent [NK][ND];

  typedef struct {
    int cl;
    int v0, v1, v2, v3;
    int exp_trunc;
    int exp_round;
  } mean_vec_t;

  mean_vec_t tbl [5];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      m_cnt[k] = 0;
      for (int d = 0; d < ND; d++) begin
        m_sum[k][d]  = 0;
        m_cent[k][d] = k * 8;
      end
    end
  endfunction

  function automatic void model_accept(input logic [3:0] lbl, input point_t p);
    if (int'(lbl) < NK && m_cnt[lbl] < 300) begin
      m_cnt[lbl]++;
      for (int d = 0; d < ND; d++) m_sum[lbl][d] += int'(p[d]);
    end
  endfunction

  function automatic void model_recalc();
    int q;
    for (int k = 0; k < NK; k++) begin
      for (int d = 0; d < ND; d++) begin
        if (m_cnt[k] != 0) begin
          q = ROUND ? (m_sum[k][d] + m_cnt[k] / 2) / m_cnt[k] : m_sum[k][d] / m_cnt[k];
          m_cent[k][d] = (q > 127) ? 127 : q;
        end
        m_sum[k][d] = 0;
      end
      m_cnt[k] = 0;
    end
  endfunction

  function automatic point_t rand_point();
    point_t p;
    for (int d = 0; d < ND; d++) p[d] = DW'($urandom_range(0, 127));
    return p;
  endfunction

  function automatic point_t fill_point(input int v);
    point_t p;
    for (int d = 0; d < ND; d++) p[d] = DW'(v);
    return p;
  endfunction

  task automatic check_all(input string tag);
    point_t e;
    for (int k = 0; k < NK; k++) begin
      for (int d = 0; d < ND; d++) e[d] = DW'(m_cent[k][d]);
      check($sformatf("%s centroid[%0d]", tag, k), fc[k], e);
    end
  endtask

  task automatic send(input logic [3:0] lbl, input point_t p);
    valid      = 1'b1;
    element_in = {lbl, p};
    model_accept(lbl, p);
    tick();
    valid = 1'b0;
  endtask

  // Request a recalculation, optionally with a same-cycle element and a mid-DIV injection.
  task automatic run_recalc(input string tag, input bit with_el, input logic [3:0] lbl,
                            input point_t p, input int inject_at);
    int lat;
    recalc = 1'b1;
    if (with_el) begin
      valid      = 1'b1;
      element_in = {lbl, p};
      model_accept(lbl, p);
    end
    model_recalc();
    lat = 0;
    while (lat < EXP_LAT + 100) begin
      tick();
      lat++;
      recalc = 1'b0;
      valid  = 1'b0;
      if (lat == inject_at) begin
        valid      = 1'b1;
        recalc     = 1'b1;
        element_in = {4'd3, fill_point(100)};
      end
      if (lat == 5) begin
        check({tag, " busy in DIV"}, busy, 1);
        check({tag, " ready in DIV"}, ready, 0);
      end
      if (update) break;
    end
    check({tag, " pulse latency"}, lat, EXP_LAT);
    check_all(tag);
    tick();
    check({tag, " pulse width"}, update, 0);
    check({tag, " ready after publish"}, ready, 1);
  endtask

  initial begin
    int base;
    point_t p;
    reset      = 1'b1;
    valid      = 1'b0;
    recalc     = 1'b0;
    element_in = '0;
    model_reset();

    tbl[0] = '{cl: 2,  v0: 10,  v1: 11,  v2: 12,  v3: 14,  exp_trunc: 11,  exp_round: 12};
    tbl[1] = '{cl: 7,  v0: 1,   v1: 2,   v2: 2,   v3: 2,   exp_trunc: 1,   exp_round: 2};
    tbl[2] = '{cl: 9,  v0: 127, v1: 127, v2: 127, v3: 126, exp_trunc: 126, exp_round: 127};
    tbl[3] = '{cl: 0,  v0: 0,   v1: 0,   v2: 0,   v3: 1,   exp_trunc: 0,   exp_round: 0};
    tbl[4] = '{cl: 13, v0: 3,   v1: 3,   v2: 4,   v3: 4,   exp_trunc: 3,   exp_round: 4};

    tick();
    tick();
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset update", update, 0);
    check("reset centroid[5]", fc[5], fill_point(40));
    check_all("reset");
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      int vals [4];
      vals = '{tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3};
      for (int j = 0; j < 4; j++) begin
        p    = rand_point();
        p[0] = DW'(vals[j]);
        send(4'(tbl[i].cl), p);
      end
      run_recalc($sformatf("mean%0d", i), 1'b0, 4'd0, '0, -1);
      check($sformatf("mean%0d dim0", i), fc[tbl[i].cl][0],
            ROUND ? tbl[i].exp_round : tbl[i].exp_trunc);
    end

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 3) != 0) send(4'($urandom_range(0, 15)), rand_point());
        else tick();
      end
      run_recalc($sformatf("rand%0d", r), 1'b0, 4'd0, '0, -1);
    end

    send(4'd15, fill_point(90));
    send(4'd14, fill_point(90));
    run_recalc("bad label", 1'b0, 4'd0, '0, -1);

    for (int n = 0; n < 301; n++) send(4'd0, fill_point(127));
    send(4'd0, fill_point(0));
    run_recalc("saturate", 1'b0, 4'd0, '0, -1);
    check("saturate cluster0", fc[0], fill_point(127));

    run_recalc("same cycle", 1'b1, 4'd1, fill_point(50), -1);
    check("same cycle dim0", fc[1][0], 50);

    base = pulse_cnt;
    run_recalc("inject", 1'b0, 4'd0, '0, 300);
    for (int n = 0; n < EXP_LAT + 50; n++) tick();
    check("single pulse", pulse_cnt - base, 1);
    run_recalc("drop check", 1'b0, 4'd0, '0, -1);

    for (int n = 0; n < 4; n++) send(4'd4, fill_point(20));
    recalc = 1'b1;
    tick();
    recalc = 1'b0;
    for (int n = 0; n < 499; n++) tick();
    check("abort busy before reset", busy, 1);
    base  = pulse_cnt;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check("abort ready", ready, 1);
    check("abort busy", busy, 0);
    check("abort update", update, 0);
    check_all("abort");
    for (int n = 0; n < EXP_LAT + 50; n++) tick();
    check("abort no pulse", pulse_cnt - base, 0);
    run_recalc("post abort", 1'b0, 4'd0, '0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/centroid_update_unit.md
Name: centroid_update_unit

Overview:
- Downstream of the k-means assignment stage. Consumes labelled elements (cluster id plus point) and keeps a per-cluster, per-dimension running sum and a per-cluster count.
- On `recalculate_centroids` it runs a sequential divider over every (cluster, dimension) pair. It then publishes new centroids on `formatted_centroids` and pulses `update_centroids` so the register file can reload them.

Parameters:
- K, 14, number of clusters (`K` shared define; package constant `K_CLUSTERS` mirrors it)
- DIMS, 5, dimensions per point
- DW, 7, bits per dimension (unsigned); DIMS*DW = 35
- LW, 4, cluster-label width, clog2(K)
- MAX_PTS, 300, per-cluster count saturation value
- CNT_W, 9, clog2(MAX_PTS+1)
- SUM_W, 16, DW+CNT_W, accumulator width

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- valid  in  1  `element_in` qualifier
- element_in  in  39  [38:35] cluster label, [34:0] point; dimension d is bits [d*7+6 : d*7]
- recalculate_centroids  in  1  single-cycle request to compute new means
- ready  out  1  high when elements are accepted (state ACCUM)
- busy  out  1  high while dividing
- formatted_centroids  out  K x 35  current centroid set, packed like the point field
- update_centroids  out  1  one-cycle pulse when `formatted_centroids` holds a fresh set

Behaviour:
- Reset (sync, active-high):
  - All sums and counts = 0; state = ACCUM; `ready` = 1; `busy` = 0; `update_centroids` = 0.
  - Centroid k, every dimension = k*8 (k=13 gives 104).
- A reset mid-division aborts it and restores the reset values above.

- ACCUM:
  - On `valid && ready` with label < K: `sum[label][d] += dim_d` for each d, and `count[label] += 1`.
  - Label >= K: element ignored.
  - `count == MAX_PTS`: element ignored; sums and count hold, with no wrap (SUM_W is sized so this cannot overflow).
  - `recalculate_centroids` in ACCUM: a same-cycle valid element is accumulated first. Next cycle state = DIV and `ready` = 0.
  - `recalculate_centroids` outside ACCUM: ignored.
  - `valid` while `ready` = 0: element dropped.

- DIV:
  - Iterates pairs in order: cluster 0 dims 0..4, then cluster 1, ..., cluster K-1.
  - Per pair: 1 LOAD cycle, then SUM_W restoring-divide iterations (1 quotient bit per cycle, MSB first). Quotient low DW bits go to a shadow centroid register, saturated to 127.
  - Cluster with count 0: skip division; its shadow dimensions = its current centroid.
  - Total DIV length = K*DIMS*(SUM_W+1) = 1190 cycles, including skipped pairs (fixed latency).
  - `busy` = 1 throughout DIV.

- PUBLISH (1 cycle):
  - The shadow set is copied to `formatted_centroids` at the cycle edge.
  - `update_centroids` = 1 for that one cycle.
  - All sums and counts clear to 0.
  - Next cycle: ACCUM, `ready` = 1.

- Latency: request cycle → `update_centroids` = 1 + 1190 + 1 = 1192 cycles.
- `formatted_centroids` changes only in the PUBLISH cycle and at reset.

Optional Feature:
- Macro: `CENTROID_ROUND_EN`.
- Defined:
  - The LOAD cycle uses dividend = sum + (count >> 1), giving round-to-nearest with ties rounding up.
  - The dividend is 1 bit wider, so there are SUM_W+1 iterations per pair; DIV length = K*DIMS*(SUM_W+2) = 1260 cycles.
- Undefined: truncating division with the latencies above.

Decomposition:
- Shared package `kmeans_pkg`:
  - constants K_CLUSTERS, DIMS, DW, LW, MAX_PTS, CNT_W, SUM_W
  - typedef `point_t` (35-bit packed DIMS x DW)
  - typedef `element_t` (label + `point_t`)
  - typedef `centroid_arr_t` (K x `point_t`)
  - enum `cu_state_t` {ACCUM, DIV, PUBLISH}
- One sub-module, `seq_divider`:
  - Restoring, start/done handshake, parameterised on dividend and divisor widths.
  - Instantiated once; the top FSM sequences the pair index.

Test Plan:
- Reset check:
  - Stimulus: reset 2 cycles.
  - Required: `formatted_centroids[5]` = five dims of 40; `ready` = 1; `busy` = 0; `update_centroids` = 0.
- Mean, truncating (macro off):
  - Stimulus: cluster 2 gets points with dim0 = 10, 11, 12, 14; then pulse recalc.
  - Required: after 1192 cycles, `update_centroids` pulses and `centroid[2]` dim0 = 11. Clusters with no elements keep k*8.
- Mean, rounding (`CENTROID_ROUND_EN`):
  - Stimulus: same stimulus as the truncating case.
  - Required: dim0 = 12 (47/4 = 11.75 rounds up); pulse 1262 cycles after the request.
- Boundaries:
  - Stimulus A: label 15. Required A: no count change.
  - Stimulus B: 301 elements to cluster 0, all dims 127. Required B: count = 300 and the result is 127 in every dimension.
  - Stimulus C: valid during DIV. Required C: the element is dropped.
- Simultaneous events:
  - Stimulus: valid with cluster 1, dim0 = 50 in the same cycle as recalc.
  - Required: the element is included, giving `centroid[1]` dim0 = 50.
- Abort:
  - Stimulus: reset asserted 500 cycles into DIV.
  - Required: reset values restored; no `update_centroids` pulse.
- Stress:
  - Stimulus: a second recalc while `busy` = 1.
  - Required: ignored; exactly one pulse is seen.
